// File: rtl/vga_fb_scanner.sv
// rtl/vga_fb_scanner.sv - VGA timing generator and 2x-upscaling frame-buffer read scanner
module vga_fb_scanner #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 320
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] fb_pixel,
    output logic [16:0] fb_read_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          tick;
    logic          tick_d;
    logic          h_last;
    logic          v_last;
    logic          active;
    logic          hs_raw;
    logic          vs_raw;
    logic [16:0]   row;
    logic [16:0]   col;
    logic [16:0]   row_base;
    logic [16:0]   pix_addr;
    logic          unused_pixel_bits;

    assign tick   = (div_cnt == DIV_LAST);
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

    // Halving both counters repeats each buffer pixel over a 2x2 block of screen pixels.
    assign row = {8'd0, v_cnt[9:1]};
    assign col = {8'd0, h_cnt[9:1]};

    generate
        if (FB_W == 320) begin : g_mul320
            assign row_base = (row << 8) + (row << 6);
        end else begin : g_mul_generic
            assign row_base = row * 17'(FB_W);
        end
    endgenerate

    assign pix_addr          = row_base + col;
    assign unused_pixel_bits = &{1'b0, fb_pixel[11], fb_pixel[5], fb_pixel[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick_d  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            tick_d  <= tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Address is issued one clk after the counters move, so read data settles before the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_read_addr <= '0;
        end else if (tick_d) begin
            fb_read_addr <= active ? pix_addr : 17'd0;
        end
    end

    // On each tick the counters still hold the pixel whose data is now on fb_pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_on <= 1'b0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            rgb      <= 12'h000;
        end else if (tick) begin
            video_on <= active;
            hsync    <= hs_raw;
            vsync    <= vs_raw;
            rgb      <= active ? {fb_pixel[15:12], fb_pixel[10:7], fb_pixel[4:1]} : 12'h000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick && h_last && (v_cnt == V_ACT - 10'd1);
        end
    end

endmodule

// File: tb/tb_vga_fb_scanner.sv
// tb/tb_vga_fb_scanner.sv - directed bench for vga_fb_scanner on a reduced 24x14 raster
module tb_vga_fb_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] fb_pixel;
    logic [16:0] fb_read_addr;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [11:0] rgb;
    logic        frame_tick;

    logic        force_en;
    logic [15:0] force_val;

    int n_checks;
    int n_fail;
    int pc;
    int hs_fall_n, hs_fall0, hs_fall1, hs_low;
    int vs_fall_n, vs_fall0, vs_fall1, vs_low;
    int ft_n, ft0, ft1;
    int vo_cnt;
    logic hs_prev, vs_prev;

    // 16x8 visible, hsync h in [18,21], vsync v in [10,11]; 24 px/line, 14 lines, 4 clk/px.
    vga_fb_scanner #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .FB_W(320)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fb_pixel(fb_pixel),
        .fb_read_addr(fb_read_addr),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .rgb(rgb),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) fb_pixel <= force_en ? force_val : fb_read_addr[15:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 0;
        else        pc <= pc + 1;
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev <= 1'b1; vs_prev <= 1'b1;
            hs_fall_n <= 0; hs_fall0 <= 0; hs_fall1 <= 0; hs_low <= 0;
            vs_fall_n <= 0; vs_fall0 <= 0; vs_fall1 <= 0; vs_low <= 0;
            ft_n <= 0; ft0 <= 0; ft1 <= 0; vo_cnt <= 0;
        end else begin
            hs_prev <= hsync;
            vs_prev <= vsync;
            if (hs_prev && !hsync) begin
                hs_fall_n <= hs_fall_n + 1;
                if (hs_fall_n == 0) hs_fall0 <= pc;
                if (hs_fall_n == 1) hs_fall1 <= pc;
            end
            if (!hs_prev && hsync && hs_fall_n == 1 && hs_low == 0) hs_low <= pc - hs_fall0;
            if (vs_prev && !vsync) begin
                vs_fall_n <= vs_fall_n + 1;
                if (vs_fall_n == 0) vs_fall0 <= pc;
                if (vs_fall_n == 1) vs_fall1 <= pc;
            end
            if (!vs_prev && vsync && vs_fall_n == 1 && vs_low == 0) vs_low <= pc - vs_fall0;
            if (frame_tick) begin
                ft_n <= ft_n + 1;
                if (ft_n == 0) ft0 <= pc;
                if (ft_n == 1) ft1 <= pc;
            end
            if (pc >= 1 && pc <= 96 && video_on) vo_cnt <= vo_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int k);
        int g;
        g = 0;
        while (pc < k && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_bound", 32'(pc >= k), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_video_on"}, 32'(video_on), 32'd0);
        chk({tag, "_rgb"}, 32'(rgb), 32'h000);
        chk({tag, "_addr"}, 32'(fb_read_addr), 32'd0);
        chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        force_en  = 1'b0;
        force_val = 16'h0000;
        rst_n     = 1'b0;
        repeat (10) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;

        wait_to(3);
        chk_reset_outputs("pre_tick");
        wait_to(4);
        chk("first_tick_video_on", 32'(video_on), 32'd1);
        wait_to(5);
        chk("addr_h1_v0", 32'(fb_read_addr), 32'd0);
        wait_to(9);
        chk("addr_h2_v0", 32'(fb_read_addr), 32'd1);
        wait_to(13);
        chk("addr_h3_v0", 32'(fb_read_addr), 32'd1);
        wait_to(61);
        chk("addr_h15_v0", 32'(fb_read_addr), 32'd7);
        wait_to(65);
        chk("addr_blank_h16", 32'(fb_read_addr), 32'd0);
        wait_to(97);
        chk("addr_h0_v1", 32'(fb_read_addr), 32'd0);
        wait_to(193);
        chk("addr_h0_v2", 32'(fb_read_addr), 32'd320);
        wait_to(196);
        chk("rgb_h0_v2", 32'(rgb), 32'h020);

        wait_to(200);
        force_en  = 1'b1;
        force_val = 16'hF800;
        wait_to(204);
        chk("rgb_red", 32'(rgb), 32'hF00);
        force_val = 16'h07E0;
        wait_to(208);
        chk("rgb_green", 32'(rgb), 32'h0F0);
        force_val = 16'hFFFF;
        wait_to(256);
        chk("rgb_white_active", 32'(rgb), 32'hFFF);
        wait_to(260);
        chk("rgb_white_blank", 32'(rgb), 32'h000);
        chk("video_on_blank", 32'(video_on), 32'd0);
        force_en = 1'b0;

        wait_to(289);
        chk("addr_h0_v3", 32'(fb_read_addr), 32'd320);
        wait_to(733);
        chk("addr_last_pixel", 32'(fb_read_addr), 32'd967);
        wait_to(736);
        chk("rgb_last_pixel", 32'(rgb), 32'h073);
        chk("video_on_last_pixel", 32'(video_on), 32'd1);
        wait_to(768);
        chk("frame_tick_high", 32'(frame_tick), 32'd1);
        wait_to(769);
        chk("frame_tick_low", 32'(frame_tick), 32'd0);
        wait_to(1344);
        chk("video_on_frame_end", 32'(video_on), 32'd0);
        wait_to(1348);
        chk("video_on_wrap_00", 32'(video_on), 32'd1);
        wait_to(1353);
        chk("addr_wrap_h2_v0", 32'(fb_read_addr), 32'd1);

        wait_to(2320);
        chk("hs_fall0", 32'(hs_fall0), 32'd76);
        chk("hs_period", 32'(hs_fall1 - hs_fall0), 32'd96);
        chk("hs_low_len", 32'(hs_low), 32'd16);
        chk("video_on_per_line", 32'(vo_cnt), 32'd64);
        chk("vs_fall0", 32'(vs_fall0), 32'd964);
        chk("vs_low_len", 32'(vs_low), 32'd192);
        chk("vs_period", 32'(vs_fall1 - vs_fall0), 32'd1344);
        chk("frame_tick_count", 32'(ft_n), 32'd2);
        chk("frame_tick_first", 32'(ft0), 32'd768);
        chk("frame_tick_period", 32'(ft1 - ft0), 32'd1344);

        wait_to(3210);
        chk("pre_reset_video_on", 32'(video_on), 32'd1);
        chk("pre_reset_rgb", 32'(rgb), 32'h052);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_to(75);
        chk("post_reset_no_early_hs", 32'(hs_fall_n), 32'd0);
        wait_to(76);
        chk("post_reset_hs_fall", 32'(hsync), 32'd0);
        wait_to(800);
        chk("post_reset_hs_fall0", 32'(hs_fall0), 32'd76);
        chk("post_reset_ft_count", 32'(ft_n), 32'd1);
        chk("post_reset_ft0", 32'(ft0), 32'd768);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
